// File: rtl/seg7_pkg.sv
// seg7_pkg: segment patterns shared by the display encoder and capture side, plus capture FSM states
package seg7_pkg;
    localparam logic [6:0] SEG_0     = 7'b1111110;
    localparam logic [6:0] SEG_1     = 7'b0110000;
    localparam logic [6:0] SEG_2     = 7'b1101101;
    localparam logic [6:0] SEG_3     = 7'b1111001;
    localparam logic [6:0] SEG_4     = 7'b0110011;
    localparam logic [6:0] SEG_5     = 7'b1011011;
    localparam logic [6:0] SEG_6     = 7'b1011111;
    localparam logic [6:0] SEG_7     = 7'b1110000;
    localparam logic [6:0] SEG_8     = 7'b1111111;
    localparam logic [6:0] SEG_9     = 7'b1111011;
    localparam logic [6:0] SEG_BLANK = 7'b0000000;

    typedef enum logic [1:0] {S_IDLE, S_SETTLE, S_HOLD} state_t;
endpackage

// File: rtl/seg7_decode.sv
// seg7_decode: active-high {a..g} pattern to BCD digit with legality flag
module seg7_decode
    import seg7_pkg::*;
(
    input  logic [6:0] seg,
    input  logic       allow_blank,
    output logic [3:0] digit,
    output logic       legal
);
    always_comb begin
        digit = 4'd0;
        legal = 1'b1;
        case (seg)
            SEG_0:     digit = 4'd0;
            SEG_1:     digit = 4'd1;
            SEG_2:     digit = 4'd2;
            SEG_3:     digit = 4'd3;
            SEG_4:     digit = 4'd4;
            SEG_5:     digit = 4'd5;
            SEG_6:     digit = 4'd6;
            SEG_7:     digit = 4'd7;
            SEG_8:     digit = 4'd8;
            SEG_9:     digit = 4'd9;
            SEG_BLANK: legal = allow_blank;
            default:   legal = 1'b0;
        endcase
    end
endmodule

// File: rtl/seg7_mux_capture.sv
// seg7_mux_capture: samples a multiplexed two-digit 7-segment bus and rebuilds the signed displayed value
module seg7_mux_capture
    import seg7_pkg::*;
#(
    parameter bit SEG_ACTIVE_LOW = 1'b1,
    parameter bit DIG_ACTIVE_LOW = 1'b1,
    parameter int SETTLE         = 4,
    parameter int TIMEOUT        = 65535
) (
    input  logic       clk_in,
    input  logic       rst_n,
    input  logic       a,
    input  logic       b,
    input  logic       c,
    input  logic       d,
    input  logic       e,
    input  logic       f,
    input  logic       g,
    input  logic       sign0,
    input  logic       dis1,
    input  logic       dis0,
    output logic       valid_out,
    output logic [7:0] value_out,
    output logic [3:0] tens_out,
    output logic [3:0] units_out,
    output logic       neg_out,
    output logic       err_out,
    output logic       stale_out
);
    localparam int TW = $clog2(TIMEOUT + 1);

    logic [6:0]    seg, lat_seg;
    logic          sgn, en1, en0, lat_sgn, lat_t, both_q, seen_t, seen_u, neg_q;
    logic [3:0]    tens_q, units_q, digit;
    logic          legal, both, one, changed, start, capture, frame, neg_nz;
    logic [7:0]    cnt, cnt_n, mag;
    logic [TW-1:0] to_cnt;
    state_t        state, state_n;

    seg7_decode u_dec (
        .seg        (seg),
        .allow_blank(en1),
        .digit      (digit),
        .legal      (legal)
    );

    assign both      = en1 & en0;
    assign one       = en1 ^ en0;
    assign changed   = !one || en1 != lat_t || seg != lat_seg || sgn != lat_sgn;
    assign start     = one && (state == S_IDLE || (state == S_HOLD && en1 != lat_t) ||
                               (state == S_SETTLE && changed));
    assign capture   = (start && SETTLE == 1) ||
                       (state == S_SETTLE && !changed && cnt == 8'(SETTLE - 1));
    assign frame     = seen_t & seen_u;
    assign mag       = 8'(tens_q) * 8'd10 + 8'(units_q);
    assign neg_nz    = neg_q && mag != 8'd0;
    assign stale_out = to_cnt == TW'(TIMEOUT);

    // normalize polarity before registering so reset leaves every line inactive
    always_ff @(posedge clk_in) begin
        if (!rst_n) begin
            seg <= '0;
            sgn <= 1'b0;
            en1 <= 1'b0;
            en0 <= 1'b0;
        end else begin
            seg <= {a, b, c, d, e, f, g} ^ {7{SEG_ACTIVE_LOW}};
            sgn <= sign0 ^ SEG_ACTIVE_LOW;
            en1 <= dis1 ^ DIG_ACTIVE_LOW;
            en0 <= dis0 ^ DIG_ACTIVE_LOW;
        end
    end

    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        if (both) state_n = S_IDLE;
        else if (capture) state_n = S_HOLD;
        else if (start) begin
            state_n = S_SETTLE;
            cnt_n   = 8'd1;
        end
        else if (!one) state_n = S_IDLE;
        else if (state == S_SETTLE) cnt_n = cnt + 8'd1;
    end

    always_ff @(posedge clk_in) begin
        if (!rst_n) begin
            state     <= S_IDLE;
            cnt       <= '0;
            lat_seg   <= '0;
            lat_sgn   <= 1'b0;
            lat_t     <= 1'b0;
            both_q    <= 1'b0;
            seen_t    <= 1'b0;
            seen_u    <= 1'b0;
            tens_q    <= '0;
            units_q   <= '0;
            neg_q     <= 1'b0;
            to_cnt    <= '0;
            valid_out <= 1'b0;
            err_out   <= 1'b0;
            value_out <= '0;
            tens_out  <= '0;
            units_out <= '0;
            neg_out   <= 1'b0;
        end else begin
            state     <= state_n;
            cnt       <= cnt_n;
            both_q    <= both;
            err_out   <= (both && !both_q) || (capture && !legal);
            valid_out <= frame;
            to_cnt    <= frame ? '0 : to_cnt + TW'(!stale_out);
            if (start) begin
                lat_t   <= en1;
                lat_seg <= seg;
                lat_sgn <= sgn;
            end
            if (frame || both || (capture && !legal)) begin
                seen_t <= 1'b0;
                seen_u <= 1'b0;
            end
            // a capture landing on the frame cycle starts the next frame
            if (capture && legal && en1) begin
                seen_t <= 1'b1;
                tens_q <= digit;
                neg_q  <= sgn;
            end else if (capture && legal) begin
                seen_u  <= 1'b1;
                units_q <= digit;
            end
            if (frame) begin
                value_out <= neg_nz ? 8'd0 - mag : mag;
                tens_out  <= tens_q;
                units_out <= units_q;
                neg_out   <= neg_nz;
            end
        end
    end
endmodule

// File: tb/tb_seg7_mux_capture.sv
// tb_seg7_mux_capture: table, hand-written and random frames checked against an arithmetic model
module tb_seg7_mux_capture;
    logic       clk_in = 1'b0;
    logic       rst_n = 1'b0;
    logic       a, b, c, d, e, f, g, sign0, dis1, dis0;
    logic       valid_out, neg_out, err_out, stale_out;
    logic [7:0] value_out;
    logic [3:0] tens_out, units_out;

    int total = 0, passed = 0, nvalid = 0, nerr = 0;
    logic [6:0] segtab [10];

    typedef struct {
        int t; bit blank; bit ng; int u; bit uf;
        int ev; int et; int eu; int en;
    } vec_t;
    vec_t vecs [7];

    always #5 clk_in = ~clk_in;

    seg7_mux_capture #(.TIMEOUT(100)) dut (
        .clk_in(clk_in), .rst_n(rst_n),
        .a(a), .b(b), .c(c), .d(d), .e(e), .f(f), .g(g),
        .sign0(sign0), .dis1(dis1), .dis0(dis0),
        .valid_out(valid_out), .value_out(value_out), .tens_out(tens_out),
        .units_out(units_out), .neg_out(neg_out), .err_out(err_out), .stale_out(stale_out)
    );

    always @(negedge clk_in) begin
        if (valid_out) nvalid++;
        if (err_out) nerr++;
    end

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act != exp) $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        else passed++;
    endtask

    task automatic drive(input bit t_en, input bit u_en, input logic [6:0] s, input bit sg, input int n);
        repeat (n) begin
            @(posedge clk_in);
            #1;
            {a, b, c, d, e, f, g} = ~s;
            sign0 = ~sg;
            dis1  = ~t_en;
            dis0  = ~u_en;
        end
    endtask

    task automatic idle(input int n);
        drive(1'b0, 1'b0, 7'h00, 1'b0, n);
    endtask

    task automatic win(input bit tens, input logic [6:0] s, input bit sg, input int n);
        drive(tens, !tens, s, sg, n);
    endtask

    function automatic int model(input int t, input int u, input bit ng);
        int m;
        m = t * 10 + u;
        return (ng && m != 0) ? -m : m;
    endfunction

    task automatic frame(input string name, input int t, input bit blank, input bit ng, input int u,
                         input bit uf, input int ev, input int et, input int eu, input int en);
        int v0, e0, n;
        logic [6:0] ts, us;
        v0 = nvalid;
        e0 = nerr;
        ts = blank ? 7'h00 : segtab[t];
        us = segtab[u];
        n  = $urandom_range(5, 8);
        if ($urandom_range(0, 2) == 0) win(!uf, segtab[$urandom_range(0, 9)], ng, $urandom_range(1, 3));
        if (uf) begin
            win(1'b0, us, 1'($urandom_range(0, 1)), n);
            idle(2);
            win(1'b1, ts, ng, n);
        end else begin
            win(1'b1, ts, ng, n);
            idle(2);
            win(1'b0, us, 1'($urandom_range(0, 1)), n);
        end
        idle(6);
        chk({name, " valid"}, nvalid - v0, 1);
        chk({name, " err"}, nerr - e0, 0);
        chk({name, " value"}, int'($signed(value_out)), ev);
        chk({name, " tens"}, int'(tens_out), et);
        chk({name, " units"}, int'(units_out), eu);
        chk({name, " neg"}, int'(neg_out), en);
    endtask

    initial begin
        int v0, e0, t, u;
        bit ng, blank;
        segtab = '{7'b1111110, 7'b0110000, 7'b1101101, 7'b1111001, 7'b0110011,
                   7'b1011011, 7'b1011111, 7'b1110000, 7'b1111111, 7'b1111011};
        vecs[0] = '{2, 0, 0, 1, 1, 21, 2, 1, 0};
        vecs[1] = '{0, 1, 1, 9, 0, -9, 0, 9, 1};
        vecs[2] = '{3, 0, 0, 0, 0, 30, 3, 0, 0};
        vecs[3] = '{9, 0, 1, 9, 1, -99, 9, 9, 1};
        vecs[4] = '{0, 1, 1, 0, 0, 0, 0, 0, 0};
        vecs[5] = '{9, 0, 0, 9, 0, 99, 9, 9, 0};
        vecs[6] = '{0, 0, 1, 7, 1, -7, 0, 7, 1};
        {a, b, c, d, e, f, g} = 7'h7F;
        sign0 = 1'b1;
        dis1  = 1'b1;
        dis0  = 1'b1;
        repeat (3) @(posedge clk_in);
        #1 rst_n = 1'b1;
        @(negedge clk_in);
        chk("rst valid", int'(valid_out), 0);
        chk("rst err", int'(err_out), 0);
        chk("rst value", int'(value_out), 0);
        chk("rst tens", int'(tens_out), 0);
        chk("rst units", int'(units_out), 0);
        chk("rst neg", int'(neg_out), 0);
        chk("rst stale", int'(stale_out), 0);
        repeat (99) @(posedge clk_in);
        @(negedge clk_in);
        chk("stale at 99", int'(stale_out), 0);
        @(negedge clk_in);
        chk("stale at 100", int'(stale_out), 1);

        for (int i = 0; i < 7; i++)
            frame($sformatf("vec%0d", i), vecs[i].t, vecs[i].blank, vecs[i].ng, vecs[i].u,
                  vecs[i].uf, vecs[i].ev, vecs[i].et, vecs[i].eu, vecs[i].en);
        chk("stale cleared", int'(stale_out), 0);

        v0 = nvalid; e0 = nerr;
        win(1'b0, segtab[9], 1'b0, 3);
        win(1'b0, segtab[5], 1'b0, 5);
        idle(2);
        win(1'b1, 7'h00, 1'b0, 6);
        idle(6);
        chk("glitch valid", nvalid - v0, 1);
        chk("glitch err", nerr - e0, 0);
        chk("glitch value", int'($signed(value_out)), 5);

        v0 = nvalid; e0 = nerr;
        win(1'b0, 7'b0000001, 1'b0, 5);
        idle(6);
        chk("illegal err", nerr - e0, 1);
        chk("illegal valid", nvalid - v0, 0);
        v0 = nvalid; e0 = nerr;
        win(1'b0, 7'h00, 1'b0, 5);
        idle(6);
        chk("blank units err", nerr - e0, 1);
        chk("blank units valid", nvalid - v0, 0);
        frame("after illegal", 3, 0, 0, 0, 0, 30, 3, 0, 0);

        v0 = nvalid; e0 = nerr;
        win(1'b0, segtab[4], 1'b0, 6);
        idle(2);
        drive(1'b1, 1'b1, segtab[4], 1'b0, 2);
        idle(2);
        win(1'b1, segtab[1], 1'b0, 6);
        idle(2);
        win(1'b0, segtab[2], 1'b0, 6);
        idle(6);
        chk("both err", nerr - e0, 1);
        chk("both valid", nvalid - v0, 1);
        chk("both value", int'($signed(value_out)), 12);

        for (int i = 0; i < 20; i++) begin
            t     = $urandom_range(0, 9);
            u     = $urandom_range(0, 9);
            ng    = 1'($urandom_range(0, 1));
            blank = t == 0 && $urandom_range(0, 1) == 1;
            frame($sformatf("rnd%0d", i), t, blank, ng, u, 1'($urandom_range(0, 1)),
                  model(t, u, ng), t, u, int'(ng && model(t, u, ng) != 0));
        end

        frame("pre reset", 4, 0, 1, 2, 0, -42, 4, 2, 1);
        v0 = nvalid;
        win(1'b1, segtab[7], 1'b0, 6);
        idle(2);
        win(1'b0, segtab[3], 1'b0, 2);
        rst_n = 1'b0;
        @(posedge clk_in);
        #1 rst_n = 1'b1;
        @(negedge clk_in);
        chk("mid rst value", int'(value_out), 0);
        chk("mid rst tens", int'(tens_out), 0);
        chk("mid rst units", int'(units_out), 0);
        chk("mid rst neg", int'(neg_out), 0);
        chk("mid rst stale", int'(stale_out), 0);
        win(1'b0, segtab[3], 1'b0, 6);
        idle(6);
        chk("partial discarded", nvalid - v0, 0);
        win(1'b1, segtab[8], 1'b0, 6);
        idle(6);
        chk("post rst valid", nvalid - v0, 1);
        chk("post rst value", int'($signed(value_out)), 83);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule

// File: doc/seg7_mux_capture.md
Name: seg7_mux_capture

Overview:
- Receive-side counterpart of the add/sub result display path.
- Samples the multiplexed 7-segment bus (a..g, sign0, dis1, dis0) that the arithmetic top drives.
- Decodes each digit pattern back to BCD and reassembles the signed displayed result.
- Used in hardware loopback self-check and as a synthesizable checker in benches, in place of waveform inspection.

Parameters:
- SEG_ACTIVE_LOW, 1, segment lines a..g and sign0 are asserted low.
- DIG_ACTIVE_LOW, 1, digit enables dis1/dis0 are asserted low.
- SETTLE, 4, consecutive stable cycles required inside a digit window before capture (range 1..255).
- TIMEOUT, 65535, cycles without a completed frame before stale_out asserts.

Ports:
- clk_in  input  1  system clock
- rst_n  input  1  synchronous reset, active-low
- a, b, c, d, e, f, g  input  1 each  segment lines, polarity per SEG_ACTIVE_LOW
- sign0  input  1  minus indicator, polarity per SEG_ACTIVE_LOW
- dis1  input  1  tens-digit enable, polarity per DIG_ACTIVE_LOW
- dis0  input  1  units-digit enable, polarity per DIG_ACTIVE_LOW
- valid_out  output  1  one-cycle pulse: new frame on value_out/tens_out/units_out/neg_out
- value_out  output  8  signed two's-complement displayed value, -99..99
- tens_out  output  4  decoded tens BCD
- units_out  output  4  decoded units BCD
- neg_out  output  1  sign captured with the tens digit
- err_out  output  1  one-cycle pulse: illegal pattern or both enables active
- stale_out  output  1  level: no complete frame within TIMEOUT cycles

Behaviour:
- Inputs are registered once on entry (1-cycle input stage). They are then normalized to an active-high vector seg = {a,b,c,d,e,f,g} plus active-high sign and enables.
- Decode table (seg -> digit):
  - 1111110->0, 0110000->1, 1101101->2, 1111001->3, 0110011->4
  - 1011011->5, 1011111->6, 1110000->7, 1111111->8, 1111011->9
  - 0000000 (blank): legal on tens only, where it means 0.
  - Any other pattern, or blank on units: illegal.
- FSM states:
  - IDLE: no enable active. Go to SETTLE when exactly one enable is active; latch which digit, the seg value and sign; load counter=1.
  - SETTLE: if the enable set or seg/sign changes, restart with counter=1 on the new sample (go to IDLE if no enable is active). When counter reaches SETTLE, decode and go to HOLD.
    - Legal pattern: store the digit in the tens or units slot and set that slot's "seen" bit. Sign is stored with tens only.
    - Illegal pattern: pulse err_out, clear both seen bits.
  - HOLD: wait until the enable deasserts or switches digit, then go to IDLE or SETTLE respectively. Seg changes inside HOLD are ignored.
- Both enables active (any state): pulse err_out, clear seen bits, go to IDLE. Repeated error cycles pulse err_out once per entry.
- Frame completion:
  - On the cycle a capture sets the second seen bit, the next cycle asserts valid_out for 1 cycle and updates the outputs.
  - value_out = ±(tens*10 + units), negative iff neg; -0 is reported as 0 with neg_out=0.
  - Seen bits then clear.
  - Re-capturing the same digit before the other one overwrites it; only the latest values are used.
- Latency: last sample of a valid units/tens window to valid_out = SETTLE + 2 cycles (input register + output register).
- stale_out:
  - Counter increments every cycle and saturates at TIMEOUT.
  - It clears on valid_out.
  - stale_out=1 while the counter equals TIMEOUT.
- Reset (rst_n=0 at a clk_in edge):
  - valid_out=0, err_out=0, value_out=0, tens_out=0, units_out=0, neg_out=0, stale_out=0.
  - FSM=IDLE, seen bits cleared, settle and timeout counters=0.
  - Reset mid-window discards the partial frame. The first capture after reset requires a fresh full SETTLE window.

Decomposition:
- Shared package seg7_pkg:
  - 7-bit segment constants SEG_0..SEG_9 and SEG_BLANK (shared with the existing display encoder so both ends use one table).
  - FSM state encoding (IDLE, SETTLE, HOLD).
- One sub-module, seg7_decode: combinational seg[6:0] + allow_blank -> digit[3:0], legal.

Test Plan:
- Parameters at defaults, active-low. dis0 window with seg 0110000 (units 1) for 6 cycles, then dis1 window with seg 1101101 (tens 2), sign0 inactive, for 6 cycles -> valid_out one pulse, value_out=21, tens_out=2, units_out=1, neg_out=0.
- Tens window blank with sign0 active, then units window with 1111011 (9) -> value_out=-9 (8'hF7), neg_out=1, tens_out=0.
- Units window seg 1111011 held only 3 cycles, then changed to 1011011 for 5 cycles, then tens blank -> value_out=5 (glitch rejected, no err_out).
- Units window seg 0000001 for 5 cycles -> err_out one pulse, no valid_out; following good tens=3, units=0 frame -> value_out=30.
- dis1 and dis0 both asserted for 2 cycles mid-frame -> single err_out pulse, partial frame discarded, next full frame reported normally.
- TIMEOUT=100, no enables after reset -> stale_out rises at cycle 100. Then rst_n low for 1 cycle mid-units-window -> all outputs 0, no valid_out until a fresh frame completes.
